// File: rtl/mcpu_harness_pkg.sv
// mcpu_harness_pkg
// Shared definitions for the MCPU run harness: the harness state encoding
// (also exposed on the 'state' output) and the default opcode values.
package mcpu_harness_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_LOAD  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Default instruction encodings of the MCPU family core.
    localparam logic [5:0] DEF_OUT_OPCODE = 6'b111011;
    localparam logic [5:0] DEF_IDLE_INST  = 6'b111001;

endpackage

// File: rtl/mcpu_harness_fifo.sv
// mcpu_harness_fifo
// Synchronous FIFO holding captured core outputs. The caller decides what
// happens to a push into a full FIFO; here such a push is simply not taken
// unless a pop happens in the same cycle, in which case both succeed.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (flushes)
//   push, push_data   : write request and data
//   pop               : read request (ignored while empty)
//   rd_data           : head entry, valid while !empty
//   full, empty       : occupancy flags
module mcpu_harness_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign do_pop_s  = pop && !empty;
    // A push into a full FIFO only lands when the head leaves this cycle.
    assign do_push_s = push && (!full || do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mcpu_run_harness.sv
// mcpu_run_harness
// Run harness for the MCPU core: loadable program memory, core reset
// sequencing, OUT-instruction capture into a drainable FIFO, and a RUN cycle
// counter with an optional cycle limit.
// Optional feature macro MCPU_HARNESS_TIMESTAMP_EN: adds out_stamp, the RUN
// cycle count recorded with each captured value.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   load_we, load_addr, load_data   : program write port (LOAD state only)
//   start                           : leave LOAD and sequence the core reset
//   cpu_addr                        : core address/output bus
//   cpu_inst, cpu_reset             : instruction and reset to the core
//   out_data, out_valid, out_ready  : captured-output FIFO drain
//   out_stamp                       : capture cycle (timestamp build only)
//   cycles, state, halted, overflow : run status
module mcpu_run_harness
    import mcpu_harness_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter int                INST_W       = 6,
    parameter logic [INST_W-1:0] OUT_OPCODE   = INST_W'(DEF_OUT_OPCODE),
    parameter logic [INST_W-1:0] IDLE_INST    = INST_W'(DEF_IDLE_INST),
    parameter int                RESET_CYCLES = 2,
    parameter int                FIFO_DEPTH   = 8,
    parameter int                CYC_W        = 16,
    parameter int                MAX_CYCLES   = 10000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INST_W-1:0]  load_data,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic [INST_W-1:0]  cpu_inst,
    output logic               cpu_reset,
    output logic [ADDR_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef MCPU_HARNESS_TIMESTAMP_EN
    output logic [CYC_W-1:0]   out_stamp,
`endif
    output logic [CYC_W-1:0]   cycles,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic               overflow
);

    localparam int MEM_DEPTH = 1 << ADDR_W;
`ifdef MCPU_HARNESS_TIMESTAMP_EN
    localparam int FIFO_W = CYC_W + ADDR_W;
`else
    localparam int FIFO_W = ADDR_W;
`endif
    // The limit only applies when it is representable in the counter.
    localparam bit LIMIT_EN = (MAX_CYCLES > 0) &&
                              (longint'(MAX_CYCLES) < (longint'(1) << CYC_W));
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);
    localparam logic [CYC_W-1:0] CYC_SAT   = {CYC_W{1'b1}};

    logic [INST_W-1:0] prog_mem_r [MEM_DEPTH];
    state_e            state_r;
    logic [3:0]        rst_cnt_r;
    logic [INST_W-1:0] inst_r;
    logic              cpu_reset_r;
    logic [CYC_W-1:0]  cycles_r;
    logic              halted_r;
    logic              overflow_r;

    logic [INST_W-1:0] fetch_s;
    logic              capture_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FIFO_W-1:0] fifo_wdata_s;
    logic [FIFO_W-1:0] fifo_rdata_s;

    assign fetch_s   = prog_mem_r[cpu_addr];
    // The instruction the core currently sees decides capture of the bus value.
    assign capture_s = (state_r == ST_RUN) && (inst_r == OUT_OPCODE);
    assign pop_s     = !fifo_empty_s && out_ready;
    assign push_s    = capture_s && (!fifo_full_s || pop_s);
    assign drop_s    = capture_s && fifo_full_s && !pop_s;

`ifdef MCPU_HARNESS_TIMESTAMP_EN
    assign fifo_wdata_s = {cycles_r, cpu_addr};
    assign out_stamp    = fifo_rdata_s[FIFO_W-1:ADDR_W];
`else
    assign fifo_wdata_s = cpu_addr;
`endif

    // Program memory write port; deliberately outside reset so programs survive it.
    always_ff @(posedge clk) begin
        if ((state_r == ST_LOAD) && load_we) begin
            prog_mem_r[load_addr] <= load_data;
        end
    end

    // Harness FSM with registered core-facing and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_LOAD;
            rst_cnt_r   <= 4'd0;
            inst_r      <= IDLE_INST;
            cpu_reset_r <= 1'b1;
            cycles_r    <= CYC_W'(0);
            halted_r    <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_LOAD: begin
                    inst_r      <= IDLE_INST;
                    cpu_reset_r <= 1'b1;
                    if (start) begin
                        state_r   <= ST_RESET;
                        rst_cnt_r <= 4'(RESET_CYCLES);
                    end
                end
                ST_RESET: begin
                    inst_r      <= IDLE_INST;
                    // Counter was loaded on entry, so release on its last cycle.
                    if (rst_cnt_r <= 4'd1) begin
                        state_r     <= ST_RUN;
                        cpu_reset_r <= 1'b0;
                        cycles_r    <= CYC_W'(0);
                    end else begin
                        cpu_reset_r <= 1'b1;
                        rst_cnt_r   <= rst_cnt_r - 4'd1;
                    end
                end
                ST_RUN: begin
                    if (LIMIT_EN && (cycles_r == CYC_LAST)) begin
                        state_r     <= ST_HALT;
                        halted_r    <= 1'b1;
                        cpu_reset_r <= 1'b1;
                        inst_r      <= IDLE_INST;
                        cycles_r    <= CYC_LIMIT;
                    end else begin
                        inst_r <= fetch_s;
                        if (cycles_r != CYC_SAT) begin
                            cycles_r <= cycles_r + CYC_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    inst_r      <= IDLE_INST;
                    cpu_reset_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_LOAD;
                    inst_r      <= IDLE_INST;
                    cpu_reset_r <= 1'b1;
                end
            endcase
        end
    end

    mcpu_harness_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (fifo_wdata_s),
        .pop       (pop_s),
        .rd_data   (fifo_rdata_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign cpu_inst  = inst_r;
    assign cpu_reset = cpu_reset_r;
    assign out_data  = fifo_rdata_s[ADDR_W-1:0];
    assign out_valid = !fifo_empty_s;
    assign cycles    = cycles_r;
    assign state     = state_r;
    assign halted    = halted_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_mcpu_run_harness.sv
// Self-checking bench for mcpu_run_harness (MAX_CYCLES = 20). A small
// reference model predicts the core-facing outputs and a queue scoreboard
// holds expected FIFO entries pushed on capture and popped on drain.
module tb_mcpu_run_harness;

    localparam int         MAXC  = 20;
    localparam int         DEPTH = 8;
    localparam logic [5:0] OUTOP = 6'h3B;
    localparam logic [5:0] IDLE  = 6'h39;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_we = 1'b0;
    logic [7:0]  load_addr = 8'd0;
    logic [5:0]  load_data = 6'd0;
    logic        start = 1'b0;
    logic [7:0]  cpu_addr = 8'd0;
    logic [5:0]  cpu_inst;
    logic        cpu_reset;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_stamp;
    logic [15:0] cycles;
    logic [1:0]  state;
    logic        halted;
    logic        overflow;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] stamp;
    } ent_t;

    ent_t        mq[$];
    logic [5:0]  m_mem [256];
    bit          m_run;
    bit          m_halt;
    bit          m_ovf;
    logic [5:0]  m_inst;
    logic [15:0] m_cycles;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

`ifndef MCPU_HARNESS_TIMESTAMP_EN
    assign out_stamp = 16'd0;
`endif

    mcpu_run_harness #(
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .cpu_addr  (cpu_addr),
        .cpu_inst  (cpu_inst),
        .cpu_reset (cpu_reset),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MCPU_HARNESS_TIMESTAMP_EN
        .out_stamp (out_stamp),
`endif
        .cycles    (cycles),
        .state     (state),
        .halted    (halted),
        .overflow  (overflow)
    );

    // One clock: compare every observable output with the model at the
    // negedge, then advance the model across the coming rising edge.
    task automatic step(input logic [7:0] addr, input logic rdy);
        logic [1:0] exp_state;
        bit         full;
        bit         pop;
        bit         cap;
        ent_t       e;
        @(negedge clk);
        cpu_addr  = addr;
        out_ready = rdy;
        #1;
        exp_state = m_halt ? 2'd3 : (m_run ? 2'd2 : 2'd0);
        n_tests++;
        if (state !== exp_state) begin
            n_fail++; $display("FAIL state: got %0d want %0d", state, exp_state);
        end
        n_tests++;
        if (cpu_reset !== !m_run) begin
            n_fail++; $display("FAIL cpu_reset: got %0b want %0b", cpu_reset, !m_run);
        end
        n_tests++;
        if (cpu_inst !== m_inst) begin
            n_fail++; $display("FAIL cpu_inst: got %0h want %0h", cpu_inst, m_inst);
        end
        n_tests++;
        if (cycles !== m_cycles) begin
            n_fail++; $display("FAIL cycles: got %0d want %0d", cycles, m_cycles);
        end
        n_tests++;
        if (halted !== m_halt) begin
            n_fail++; $display("FAIL halted: got %0b want %0b", halted, m_halt);
        end
        n_tests++;
        if (overflow !== m_ovf) begin
            n_fail++; $display("FAIL overflow: got %0b want %0b", overflow, m_ovf);
        end
        n_tests++;
        if (out_valid !== (mq.size() > 0)) begin
            n_fail++; $display("FAIL out_valid: got %0b want %0b", out_valid, mq.size() > 0);
        end
        if (mq.size() > 0) begin
            n_tests++;
            if (out_data !== mq[0].addr) begin
                n_fail++; $display("FAIL out_data: got %0d want %0d", out_data, mq[0].addr);
            end
`ifdef MCPU_HARNESS_TIMESTAMP_EN
            n_tests++;
            if (out_stamp !== mq[0].stamp) begin
                n_fail++; $display("FAIL out_stamp: got %0d want %0d", out_stamp, mq[0].stamp);
            end
`endif
        end
        // Model of the edge: pop, then capture (full+pop both succeed), then fetch.
        full = (mq.size() == DEPTH);
        pop  = rdy && (mq.size() > 0);
        cap  = m_run && (m_inst == OUTOP);
        if (pop) e = mq.pop_front();
        if (cap) begin
            if (!full || pop) begin
                e.addr  = addr;
                e.stamp = m_cycles;
                mq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (m_run) begin
            if (m_cycles == 16'(MAXC - 1)) begin
                m_run    = 1'b0;
                m_halt   = 1'b1;
                m_cycles = 16'(MAXC);
                m_inst   = IDLE;
            end else begin
                m_inst   = m_mem[addr];
                m_cycles = m_cycles + 16'd1;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; load_we = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        mq.delete();
        m_run = 1'b0; m_halt = 1'b0; m_ovf = 1'b0;
        m_inst = IDLE; m_cycles = 16'd0;
    endtask

    task automatic load(input logic [7:0] a, input logic [5:0] d);
        @(negedge clk);
        load_we = 1'b1; load_addr = a; load_data = d;
        @(posedge clk);
        #1 load_we = 1'b0;
        m_mem[a] = d;
    endtask

    // Pulse start (optionally with a same-cycle write) and check the reset window.
    task automatic start_run(input logic we, input logic [7:0] a, input logic [5:0] d);
        @(negedge clk);
        start = 1'b1; load_we = we; load_addr = a; load_data = d;
        n_tests++;
        if (state !== 2'd0 || cpu_reset !== 1'b1) begin
            n_fail++; $display("FAIL start_pre: got state %0d rst %0b want 0/1", state, cpu_reset);
        end
        @(posedge clk);
        #1 start = 1'b0; load_we = 1'b0;
        if (we) m_mem[a] = d;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (state !== 2'd1 || cpu_reset !== 1'b1) begin
                n_fail++; $display("FAIL reset_window: cycle %0d got state %0d rst %0b want 1/1", i, state, cpu_reset);
            end
            @(posedge clk);
        end
        m_run = 1'b1; m_inst = IDLE; m_cycles = 16'd0;
    endtask

    task automatic test_reset();
        do_reset();
        step(8'd0, 1'b0);
        step(8'd0, 1'b1);
    endtask

    task automatic test_basic();
        load(8'd0, OUTOP); load(8'd5, 6'h01); load(8'd1, 6'h01);
        load(8'd10, OUTOP); load(8'd11, 6'h01); load(8'd12, OUTOP);
        start_run(1'b0, 8'd0, 6'd0);
        step(8'd0, 1'b0);   // first RUN edge fetches mem[0]
        step(8'd5, 1'b0);   // cpu_inst is OUT: captures 5
        step(8'd5, 1'b1);   // head = 5, popped
        step(8'd5, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        start_run(1'b0, 8'd0, 6'd0);
        for (int i = 0; i < 10; i++) step(8'd10, 1'b0);
        step(8'd11, 1'b0);
        for (int i = 0; i < 9; i++) step(8'd11, 1'b1);
        step(8'd11, 1'b0);
    endtask

    task automatic test_halt();
        do_reset();
        start_run(1'b0, 8'd0, 6'd0);
        for (int i = 0; i < 3; i++) step(8'd12, 1'b0);
        for (int i = 0; i < 20; i++) step(8'd11, 1'b0);
        for (int i = 0; i < 4; i++) step(8'd11, 1'b1);
        step(8'd11, 1'b0);
    endtask

    task automatic test_load_ignore();
        do_reset();
        start_run(1'b0, 8'd0, 6'd0);
        load_we = 1'b1; load_addr = 8'd0; load_data = 6'h00;
        for (int i = 0; i < 4; i++) step(8'd0, 1'b0);
        load_we = 1'b0;
        do_reset();           // mid-RUN with entries queued
        step(8'd0, 1'b0);     // LOAD, FIFO flushed
        start_run(1'b1, 8'd2, OUTOP);
        step(8'd0, 1'b0);
        step(8'd2, 1'b0);     // mem[0] still OUT
        step(8'd1, 1'b0);     // mem[2] written alongside start
        step(8'd1, 1'b1);
        step(8'd1, 1'b1);
        step(8'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_run(1'b0, 8'd0, 6'd0);
        for (int i = 0; i < 9; i++) step(8'd10, 1'b0);   // fills to 8
        step(8'd10, 1'b1);                               // push+pop on full
        for (int i = 0; i < 9; i++) step(8'd11, 1'b1);
        step(8'd11, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_halt();
        test_load_ignore();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
